// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation-select encodings used by the datapath and its bench.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 2;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 2'b00;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 2'b01;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 2'b10;
  localparam logic [ALU_OP_W-1:0] ALU_NOT = 2'b11;

endpackage : alu_pkg

// File: rtl/alu_comb.sv
// Combinational ALU datapath: operation mux plus zero detect, no state.
module alu_comb
  import alu_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0]        a_in,
  input  logic [N-1:0]        b_in,
  input  logic [ALU_OP_W-1:0] alu_op,
  output logic [N-1:0]        result,
  output logic                zero
);

  // Carry and borrow fall off the top; every select value has a defined result.
  always_comb begin
    result = '0;
    unique case (alu_op)
      ALU_ADD: result = a_in + b_in;
      ALU_SUB: result = a_in - b_in;
      ALU_AND: result = a_in & b_in;
      ALU_NOT: result = ~b_in;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule : alu_comb

// File: rtl/alu_unit.sv
// Registered ALU: one-cycle latency result and zero flag with synchronous active-low reset.
module alu_unit
  import alu_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        Ain,
  input  logic [N-1:0]        Bin,
  input  logic [ALU_OP_W-1:0] ALUop,
  output logic [N-1:0]        path_to_C,
  output logic                path_to_status
);

  logic [N-1:0] result_d;
  logic [N-1:0] result_q;
  logic         zero_d;
  logic         zero_q;

  alu_comb #(
    .N (N)
  ) u_alu_comb (
    .a_in   (Ain),
    .b_in   (Bin),
    .alu_op (ALUop),
    .result (result_d),
    .zero   (zero_d)
  );

  // Reset loads a zero result, so the flag resets to 1 to stay consistent with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign path_to_C      = result_q;
  assign path_to_status = zero_q;

endmodule : alu_unit

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed vectors, mid-stream reset and random ops vs. an arithmetic model.
module tb_alu_unit;
  import alu_pkg::*;

  localparam int unsigned N = 16;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  Ain;
  logic [N-1:0]  Bin;
  logic [1:0]    ALUop;
  logic [N-1:0]  path_to_C;
  logic          path_to_status;

  int unsigned   n_checks;
  int unsigned   n_errors;

  logic [N-1:0]  exp_c;
  logic          exp_z;
  bit            exp_valid;

  alu_unit #(
    .N (N)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .Ain            (Ain),
    .Bin            (Bin),
    .ALUop          (ALUop),
    .path_to_C      (path_to_C),
    .path_to_status (path_to_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference result from plain integer arithmetic on the operation's definition.
  function automatic logic [N-1:0] model(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    int unsigned ai;
    int unsigned bi;
    int unsigned modulus;
    int unsigned r;
    ai      = a;
    bi      = b;
    modulus = 1 << N;
    r       = 0;
    case (op)
      ALU_ADD: r = (ai + bi) % modulus;
      ALU_SUB: r = (ai + modulus - bi) % modulus;
      ALU_AND: r = a & b;
      ALU_NOT: r = (modulus - 1) - bi;
      default: r = 0;
    endcase
    return r[N-1:0];
  endfunction

  // At each falling edge: check outputs from the previous vector, drive a new one,
  // and confirm the registered outputs do not follow the input change.
  task automatic step(input logic rst_v, input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    if (exp_valid) begin
      chk("result", {16'h0, path_to_C}, {16'h0, exp_c});
      chk("zero",   {31'h0, path_to_status}, {31'h0, exp_z});
    end
    rst_n = rst_v;
    ALUop = op;
    Ain   = a;
    Bin   = b;
    #1;
    if (exp_valid) begin
      chk("hold_result", {16'h0, path_to_C}, {16'h0, exp_c});
      chk("hold_zero",   {31'h0, path_to_status}, {31'h0, exp_z});
    end
    if (!rst_v) begin
      exp_c = '0;
      exp_z = 1'b1;
    end else begin
      exp_c = model(op, a, b);
      exp_z = (exp_c == 0);
    end
    exp_valid = 1'b1;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    exp_valid = 1'b0;
    exp_c     = '0;
    exp_z     = 1'b1;
    rst_n     = 1'b0;
    Ain       = 16'h1234;
    Bin       = 16'h5678;
    ALUop     = ALU_ADD;

    // Reset with non-zero operands present: reset must win.
    step(1'b0, ALU_ADD, 16'h1234, 16'h5678);

    step(1'b1, ALU_ADD, 16'h0000, 16'h0000);
    step(1'b1, ALU_ADD, 16'h0001, 16'h0000);
    step(1'b1, ALU_ADD, 16'h0011, 16'h0001);
    step(1'b1, ALU_ADD, 16'hFFFF, 16'hFFFF);

    step(1'b1, ALU_SUB, 16'h0007, 16'h0007);
    step(1'b1, ALU_SUB, 16'h0000, 16'h0000);
    step(1'b1, ALU_SUB, 16'h000D, 16'h0008);
    step(1'b1, ALU_SUB, 16'h0000, 16'h0001);

    step(1'b1, ALU_AND, 16'h0001, 16'h0001);
    step(1'b1, ALU_AND, 16'h0000, 16'h0000);
    step(1'b1, ALU_AND, 16'h0001, 16'h0000);
    step(1'b1, ALU_AND, 16'h0005, 16'h0004);

    step(1'b1, ALU_NOT, 16'h0001, 16'h0000);
    step(1'b1, ALU_NOT, 16'h0001, 16'hFFFF);
    step(1'b1, ALU_NOT, 16'h0000, 16'hFFFF);

    // Back-to-back with a reset in the middle of the stream.
    step(1'b1, ALU_ADD, 16'h8000, 16'h8001);
    step(1'b1, ALU_SUB, 16'h1000, 16'h0FFF);
    step(1'b0, ALU_NOT, 16'hAAAA, 16'h5555);
    step(1'b1, ALU_AND, 16'hF0F0, 16'hFF00);
    step(1'b1, ALU_NOT, 16'h1234, 16'h00FF);

    for (int i = 0; i < 300; i++) begin
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [1:0]   op;
      logic         r;
      a  = 16'($urandom);
      b  = 16'($urandom);
      op = 2'($urandom_range(0, 3));
      r  = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 7) == 0) b = a;
      if ($urandom_range(0, 7) == 0) b = ~a;
      step(r, op, a, b);
    end

    @(negedge clk);
    chk("result", {16'h0, path_to_C}, {16'h0, exp_c});
    chk("zero",   {31'h0, path_to_status}, {31'h0, exp_z});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_alu_unit
